// File: rtl/boot_sequencer.sv
// ---------------------------------------------------------------------------
// boot_sequencer
//
// Loads a program into the instruction memory from a stream of narrow beats
// and then gates the CPU enable with run / halt / single-step control. The
// CPU is held in reset from power-up until a complete program is resident,
// and again whenever a new load is started.
//
// Optional feature (compile-time macro BOOT_RUN_LIMIT_EN):
//   Adds a RUN-cycle budget of MAX_RUN cycles. When it expires the sequencer
//   drops back to HALT and raises the sticky timeout flag, which blocks
//   further run requests until the next load_start or reset. Without the
//   macro no counter is built and timeout is tied low.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load_start           pulse: begin / restart a program load (any state)
//   beat_valid/ready     beat stream handshake, beat_data LS beat first
//   beat_data            BEAT_W-bit program beat
//   imem_waddr/wdata/wr  instruction memory write port
//   run_req              level: run continuously
//   step_req             pulse: execute one instruction
//   halt_req             pulse: stop execution
//   cpu_en               CPU enable (registered)
//   cpu_rst              CPU reset, active-high (registered)
//   loaded               a full program is resident
//   timeout              sticky: run budget expired
//   dbg_state_o          current FSM state, for checkers and debug
//
// Handshake: a beat transfers on a rising clk edge where beat_valid and
// beat_ready are both 1. beat_ready does not depend on beat_valid; the
// source must hold beat_data stable while beat_valid is high and not yet
// accepted. beat_ready drops during the one-cycle WRITE bubble and in the
// cycle a load_start is seen, since that load_start discards the word.
// ---------------------------------------------------------------------------
module boot_sequencer #(
  parameter int ADDR_W  = 3,
  parameter int BEAT_W  = 5
`ifdef BOOT_RUN_LIMIT_EN
  ,
  parameter int MAX_RUN = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  beat_valid,
  input  logic [BEAT_W-1:0]     beat_data,
  output logic                  beat_ready,
  output logic [ADDR_W-1:0]     imem_waddr,
  output logic [3*BEAT_W-1:0]   imem_wdata,
  output logic                  imem_wr,
  input  logic                  run_req,
  input  logic                  step_req,
  input  logic                  halt_req,
  output logic                  cpu_en,
  output logic                  cpu_rst,
  output logic                  loaded,
  output logic                  timeout,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    HALT  = 3'd3,
    RUN   = 3'd4,
    STEP  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            beat_idx_q, beat_idx_d;
  logic [ADDR_W-1:0]     word_idx_q, word_idx_d;
  logic [2*BEAT_W-1:0]   asm_q, asm_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [3*BEAT_W-1:0]   wdata_q, wdata_d;
  logic                  loaded_q, loaded_d;
  logic                  cpu_en_q, cpu_en_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  beat_fire;
  logic                  run_blocked;

`ifdef BOOT_RUN_LIMIT_EN
  localparam int RUN_CNT_W = $clog2(MAX_RUN + 1);
  logic [RUN_CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic                  timeout_q, timeout_d;

  assign run_blocked = timeout_q;
  assign timeout     = timeout_q;
`else
  assign run_blocked = 1'b0;
  assign timeout     = 1'b0;
`endif

  // A load_start in the same cycle wins over the beat, so do not claim it.
  assign beat_ready = (state_q == LOAD) && !load_start;
  assign beat_fire  = beat_valid && beat_ready;

  // The completed word is written in WRITE unless a restart discards it.
  assign imem_wr    = (state_q == WRITE) && !load_start;

  assign imem_waddr  = waddr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_en      = cpu_en_q;
  assign cpu_rst     = cpu_rst_q;
  assign loaded      = loaded_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    word_idx_d = word_idx_q;
    asm_d      = asm_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    loaded_d   = loaded_q;
    cpu_rst_d  = cpu_rst_q;
`ifdef BOOT_RUN_LIMIT_EN
    timeout_d  = timeout_q;
    run_cnt_d  = run_cnt_q;
`endif

    if (load_start) begin
      state_d    = LOAD;
      beat_idx_d = 2'd0;
      word_idx_d = '0;
      asm_d      = '0;
      loaded_d   = 1'b0;
      cpu_rst_d  = 1'b1;
`ifdef BOOT_RUN_LIMIT_EN
      timeout_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          // Only load_start leaves IDLE.
        end

        LOAD: begin
          if (beat_fire) begin
            case (beat_idx_q)
              2'd0: begin
                asm_d[BEAT_W-1:0] = beat_data;
                beat_idx_d        = 2'd1;
              end
              2'd1: begin
                asm_d[2*BEAT_W-1:BEAT_W] = beat_data;
                beat_idx_d               = 2'd2;
              end
              default: begin
                // Third beat goes straight into the write data register.
                wdata_d    = {beat_data, asm_q};
                waddr_d    = word_idx_q;
                beat_idx_d = 2'd0;
                state_d    = WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          // Index wraps to 0 after the last word.
          word_idx_d = word_idx_q + ADDR_W'(1);
          if (word_idx_q == {ADDR_W{1'b1}}) begin
            state_d   = HALT;
            loaded_d  = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d   = LOAD;
          end
        end

        HALT: begin
          if (halt_req) begin
            state_d = HALT;
          end else if (step_req) begin
            state_d = STEP;
          end else if (run_req && !run_blocked) begin
            state_d = RUN;
`ifdef BOOT_RUN_LIMIT_EN
            run_cnt_d = '0;
`endif
          end
        end

        STEP: begin
          // A step_req seen here is dropped.
          state_d = HALT;
        end

        RUN: begin
          if (halt_req || !run_req) begin
            state_d = HALT;
          end
`ifdef BOOT_RUN_LIMIT_EN
          // run_cnt_q counts RUN cycles completed before this one, so the
          // MAX_RUN-th RUN cycle is the last.
          else if (run_cnt_q + RUN_CNT_W'(1) == RUN_CNT_W'(MAX_RUN)) begin
            state_d   = HALT;
            timeout_d = 1'b1;
          end else begin
            run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
          end
`endif
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Registered enable decoded from the next state, so it is high exactly in
  // the cycles the FSM spends in RUN or STEP. Both states are only reachable
  // through HALT, i.e. with loaded=1 and cpu_rst=0.
  assign cpu_en_d = (state_d == RUN) || (state_d == STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_idx_q <= 2'd0;
      word_idx_q <= '0;
      asm_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      loaded_q   <= 1'b0;
      cpu_en_q   <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      word_idx_q <= word_idx_d;
      asm_q      <= asm_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      loaded_q   <= loaded_d;
      cpu_en_q   <= cpu_en_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

`ifdef BOOT_RUN_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule
